dcache_responder: RTL

- Direct-mapped, write-back, write-allocate data cache.
- Sits between the pipeline's MEM stage (load/store initiator) and a slow line-wide backing memory.
- Responds to CPU word requests, and stalls the pipeline on a miss while it evicts or fills the line.
- Also acts as initiator on the memory side: line-granular req/ack handshake.

---
 rtl/dcache_responder_if.sv | 38 +++
 rtl/dcache_responder.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/dcache_responder_if.sv
// rtl/dcache_responder_if.sv - CPU-side and memory-side bus bundle for dcache_responder
//
// Purpose: groups the pipeline load/store handshake and the line-wide
// backing-memory handshake into one interface.
// Ports (signals):
//   req_i, we_i, addr_i, wdata_i   CPU request (driven by the pipeline)
//   rdata_o, stall_o               CPU response (driven by the cache)
//   mem_req_o, mem_we_o,
//   mem_addr_o, mem_wdata_o        memory request (driven by the cache)
//   mem_rdata_i, mem_ack_i         memory response (driven by the memory)
// Modports: slave = cache view, master = pipeline/memory view.
interface dcache_responder_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);
  logic              req_i;
  logic              we_i;
  logic [ADDR_W-1:0] addr_i;
  logic [31:0]       wdata_i;
  logic [31:0]       rdata_o;
  logic              stall_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [LINE_W-1:0] mem_wdata_o;
  logic [LINE_W-1:0] mem_rdata_i;
  logic              mem_ack_i;

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, mem_rdata_i, mem_ack_i,
    output rdata_o, stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output req_i, we_i, addr_i, wdata_i, mem_rdata_i, mem_ack_i,
    input  rdata_o, stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/dcache_responder.sv
// rtl/dcache_responder.sv - direct-mapped write-back write-allocate data cache
//
// Purpose: answers CPU word loads/stores from a 32-line x 8-word cache,
// stalling the pipeline while a dirty victim is written back and the
// missing line is filled over a line-wide req/ack memory port.
// Ports:
//   clk_i   clock, rising edge
//   rst_i   asynchronous active-low reset
//   bus     dcache_responder_if.slave (CPU request/response, memory request/response)
//   hit_cnt_o, miss_cnt_o  saturating hit/miss counters, present only when
//                          DCACHE_STATS_EN is defined
module dcache_responder #(
  parameter int INDEX_W  = 5,
  parameter int OFFSET_W = 3,
  parameter int ADDR_W   = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  dcache_responder_if.slave   bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]         hit_cnt_o,
  output logic [31:0]         miss_cnt_o
`endif
);
  localparam int NUM_LINES  = 2 ** INDEX_W;
  localparam int LINE_WORDS = 2 ** OFFSET_W;
  localparam int TAG_W      = ADDR_W - INDEX_W - OFFSET_W - 2;

  typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_ALLOCATE} state_t;

  state_t r_state;
  state_t w_next;

  logic [NUM_LINES-1:0]             r_valid;
  logic [NUM_LINES-1:0]             r_dirty;
  logic [TAG_W-1:0]                 r_tag  [NUM_LINES];
  logic [LINE_WORDS-1:0][31:0]      r_data [NUM_LINES];

  // Miss address is captured so the memory transaction stays coherent even
  // if the CPU misbehaves and drops or changes its request mid-miss.
  logic [TAG_W-1:0]                 r_miss_tag;
  logic [INDEX_W-1:0]               r_miss_idx;

  logic [TAG_W-1:0]    w_tag;
  logic [INDEX_W-1:0]  w_idx;
  logic [OFFSET_W-1:0] w_word;
  logic [1:0]          w_unused_addr;
  logic                w_hit;
  logic                w_miss;
  logic                w_store_hit;

  assign w_tag         = bus.addr_i[ADDR_W-1 -: TAG_W];
  assign w_idx         = bus.addr_i[OFFSET_W+2 +: INDEX_W];
  assign w_word        = bus.addr_i[2 +: OFFSET_W];
  assign w_unused_addr = bus.addr_i[1:0];

  assign w_hit       = bus.req_i & r_valid[w_idx] & (r_tag[w_idx] == w_tag);
  assign w_miss      = (r_state == S_IDLE) & bus.req_i & ~w_hit;
  // Also covers the re-check cycle after a fill, which merges a store miss.
  assign w_store_hit = (r_state == S_IDLE) & w_hit & bus.we_i;

  always_comb begin
    w_next          = r_state;
    bus.stall_o     = 1'b1;
    bus.rdata_o     = '0;
    bus.mem_req_o   = 1'b0;
    bus.mem_we_o    = 1'b0;
    bus.mem_addr_o  = '0;
    bus.mem_wdata_o = '0;
    case (r_state)
      S_IDLE: begin
        bus.stall_o = bus.req_i & ~w_hit;
        if (w_hit && !bus.we_i) begin
          bus.rdata_o = r_data[w_idx][w_word];
        end
        if (w_miss) begin
          w_next = (r_valid[w_idx] && r_dirty[w_idx]) ? S_WRITEBACK : S_ALLOCATE;
        end
      end
      S_WRITEBACK: begin
        bus.mem_req_o   = 1'b1;
        bus.mem_we_o    = 1'b1;
        bus.mem_addr_o  = {r_tag[r_miss_idx], r_miss_idx, {(OFFSET_W+2){1'b0}}};
        bus.mem_wdata_o = r_data[r_miss_idx];
        if (bus.mem_ack_i) begin
          w_next = S_ALLOCATE;
        end
      end
      S_ALLOCATE: begin
        bus.mem_req_o  = 1'b1;
        bus.mem_addr_o = {r_miss_tag, r_miss_idx, {(OFFSET_W+2){1'b0}}};
        if (bus.mem_ack_i) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= S_IDLE;
      r_valid    <= '0;
      r_dirty    <= '0;
      r_miss_tag <= '0;
      r_miss_idx <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_miss) begin
            r_miss_tag <= w_tag;
            r_miss_idx <= w_idx;
          end else if (w_store_hit) begin
            r_dirty[w_idx] <= 1'b1;
          end
        end
        S_WRITEBACK: begin
          if (bus.mem_ack_i) r_dirty[r_miss_idx] <= 1'b0;
        end
        S_ALLOCATE: begin
          if (bus.mem_ack_i) begin
            r_valid[r_miss_idx] <= 1'b1;
            r_dirty[r_miss_idx] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Tag and data arrays carry no reset; valid bits guard their contents.
  always_ff @(posedge clk_i) begin
    if (w_store_hit) begin
      r_data[w_idx][w_word] <= bus.wdata_i;
    end
    if (r_state == S_ALLOCATE && bus.mem_ack_i) begin
      r_data[r_miss_idx] <= bus.mem_rdata_i;
      r_tag[r_miss_idx]  <= r_miss_tag;
    end
  end

`ifdef DCACHE_STATS_EN
  // Marks the re-check cycle after a fill so it is not counted as a hit.
  logic r_refill;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_refill   <= 1'b0;
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else begin
      r_refill <= (r_state == S_ALLOCATE) && bus.mem_ack_i;
      if ((r_state == S_IDLE) && w_hit && !r_refill && (hit_cnt_o != 32'hFFFF_FFFF)) begin
        hit_cnt_o <= hit_cnt_o + 32'd1;
      end
      if (w_miss && (miss_cnt_o != 32'hFFFF_FFFF)) begin
        miss_cnt_o <= miss_cnt_o + 32'd1;
      end
    end
  end
`endif
endmodule
